// File: rtl/mmult_column_sequencer.sv
// Runs P mmult engines one column at a time over shared X/Y RAMs and packs their results column-major into RES RAM.
// Read ports are muxed combinationally from the active column; result writes land one cycle after each engine pulse.
module mmult_column_sequencer #(
    parameter int width          = 8,
    parameter int M              = 64,
    parameter int P              = 2,
    parameter int X_depth_bits   = 9,
    parameter int Y_depth_bits   = 5,
    parameter int RES_depth_bits = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [P-1:0]                eng_start,
    output logic [width-1:0]            eng_bias_term,
    input  logic [P*width-1:0]          bias_terms,
    input  logic [P-1:0]                eng_datapoint_done,
    input  logic [P-1:0]                eng_all_done,
    input  logic [P*width-1:0]          eng_results,
    input  logic [P-1:0]                eng_X_read_en,
    input  logic [P*X_depth_bits-1:0]   eng_X_read_address,
    input  logic [P-1:0]                eng_Y_read_en,
    input  logic [P*Y_depth_bits-1:0]   eng_Y_read_address,
    output logic                        X_read_en,
    output logic [X_depth_bits-1:0]     X_read_address,
    output logic                        Y_read_en,
    output logic [Y_depth_bits-1:0]     Y_read_address,
    output logic                        RES_write_en,
    output logic [RES_depth_bits-1:0]   RES_write_address,
    output logic [width-1:0]            RES_write_data_in
);

    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, COLLECT, DRAIN, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;

    logic                      dp_sel;
    logic                      all_done_sel;
    logic [width-1:0]          res_sel;
    logic [width-1:0]          bias_sel;
    logic                      x_en_sel;
    logic [X_depth_bits-1:0]   x_addr_sel;
    logic                      y_en_sel;
    logic [Y_depth_bits-1:0]   y_addr_sel;
    logic [RES_depth_bits-1:0] res_addr;
    logic                      last_row;
    logic                      last_col;

    // Pick the active engine's slice of every per-engine bus.
    always_comb begin
        dp_sel       = 1'b0;
        all_done_sel = 1'b0;
        res_sel      = '0;
        bias_sel     = '0;
        x_en_sel     = 1'b0;
        x_addr_sel   = '0;
        y_en_sel     = 1'b0;
        y_addr_sel   = '0;
        for (int c = 0; c < P; c++) begin
            if (col == CW'(c)) begin
                dp_sel       = eng_datapoint_done[c];
                all_done_sel = eng_all_done[c];
                res_sel      = eng_results[c*width +: width];
                bias_sel     = bias_terms[c*width +: width];
                x_en_sel     = eng_X_read_en[c];
                x_addr_sel   = eng_X_read_address[c*X_depth_bits +: X_depth_bits];
                y_en_sel     = eng_Y_read_en[c];
                y_addr_sel   = eng_Y_read_address[c*Y_depth_bits +: Y_depth_bits];
            end
        end
    end

    assign last_row = (row == RW'(M - 1));
    assign last_col = (col == CW'(P - 1));
    assign res_addr = RES_depth_bits'(col) * RES_depth_bits'(M) + RES_depth_bits'(row);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = COLLECT;
            COLLECT: if (dp_sel && last_row) state_nxt = DRAIN;
            // all_done is sticky, so it only means "ports released" once every row is in.
            DRAIN:   if (all_done_sel) state_nxt = last_col ? DONE : LAUNCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        done           = (state == DONE);
        eng_start      = (state == LAUNCH) ? (P'(1) << col) : '0;
        eng_bias_term  = bias_sel;
        X_read_en      = busy & x_en_sel;
        X_read_address = x_addr_sel;
        Y_read_en      = busy & y_en_sel;
        Y_read_address = y_addr_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (state == COLLECT && dp_sel) begin
                row <= last_row ? '0 : row + RW'(1);
            end else if (state == DRAIN && all_done_sel && !last_col) begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RES_write_en      <= 1'b0;
            RES_write_address <= '0;
            RES_write_data_in <= '0;
        end else begin
            RES_write_en <= (state == COLLECT) && dp_sel;
            if (state == COLLECT && dp_sel) begin
                RES_write_address <= res_addr;
                RES_write_data_in <= res_sel;
            end
        end
    end

endmodule

// File: tb/tb_mmult_column_sequencer.sv
// Bench for mmult_column_sequencer with P=2, M=4: engine models driven from the main process, writes checked by a scoreboard.
module tb_mmult_column_sequencer;

    localparam int W  = 8;
    localparam int M  = 4;
    localparam int P  = 2;
    localparam int XB = 9;
    localparam int YB = 5;
    localparam int RB = 3;

    logic            clk;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [P-1:0]    eng_start;
    logic [W-1:0]    eng_bias_term;
    logic [P*W-1:0]  bias_terms;
    logic [P-1:0]    eng_datapoint_done;
    logic [P-1:0]    eng_all_done;
    logic [P*W-1:0]  eng_results;
    logic [P-1:0]    eng_X_read_en;
    logic [P*XB-1:0] eng_X_read_address;
    logic [P-1:0]    eng_Y_read_en;
    logic [P*YB-1:0] eng_Y_read_address;
    logic            X_read_en;
    logic [XB-1:0]   X_read_address;
    logic            Y_read_en;
    logic [YB-1:0]   Y_read_address;
    logic            RES_write_en;
    logic [RB-1:0]   RES_write_address;
    logic [W-1:0]    RES_write_data_in;

    mmult_column_sequencer #(
        .width(W), .M(M), .P(P), .X_depth_bits(XB), .Y_depth_bits(YB), .RES_depth_bits(RB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .eng_start(eng_start), .eng_bias_term(eng_bias_term), .bias_terms(bias_terms),
        .eng_datapoint_done(eng_datapoint_done), .eng_all_done(eng_all_done),
        .eng_results(eng_results),
        .eng_X_read_en(eng_X_read_en), .eng_X_read_address(eng_X_read_address),
        .eng_Y_read_en(eng_Y_read_en), .eng_Y_read_address(eng_Y_read_address),
        .X_read_en(X_read_en), .X_read_address(X_read_address),
        .Y_read_en(Y_read_en), .Y_read_address(Y_read_address),
        .RES_write_en(RES_write_en), .RES_write_address(RES_write_address),
        .RES_write_data_in(RES_write_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RB-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    typedef struct {
        logic [P*W-1:0]  bias;
        logic [P-1:0]    xen;
        logic [P*XB-1:0] xa;
        logic [P-1:0]    yen;
        logic [P*YB-1:0] ya;
        logic [W-1:0]    e_bias;
        logic            e_xen;
        logic [XB-1:0]   e_xa;
        logic            e_yen;
        logic [YB-1:0]   e_ya;
    } vec_t;

    wr_t exp_q[$];
    int  total;
    int  bad;
    int  done_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (RES_write_en) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_write: got addr=%0d data=%0d, want no write",
                                 RES_write_address, RES_write_data_in);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", int'(RES_write_address), int'(e.addr));
                        chk("wr_data", int'(RES_write_data_in), int'(e.data));
                    end
                end
                if (done) done_cnt++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One engine run: answers its start, pulses M results, then raises all_done after done_gap cycles.
    task automatic run_engine(input int c, input int base, input int gap, input int done_gap,
                              input bit stray);
        bit             found;
        logic [P*W-1:0] r;
        wr_t            w;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (eng_start != '0) found = 1'b1;
        end
        if (!found) begin
            timeout("eng_start_wait");
            return;
        end
        chk("eng_start_onehot", int'(eng_start), 1 << c);
        chk("bias_sel", int'(eng_bias_term), int'((bias_terms >> (c*W)) & 16'h00FF));
        chk("x_addr_mux", int'(X_read_address), int'((eng_X_read_address >> (c*XB)) & 18'h001FF));
        chk("y_addr_mux", int'(Y_read_address), int'((eng_Y_read_address >> (c*YB)) & 10'h01F));
        chk("x_en_mux", int'(X_read_en), int'(eng_X_read_en[c]));
        chk("y_en_mux", int'(Y_read_en), int'(eng_Y_read_en[c]));
        @(negedge clk);
        chk("eng_start_1cyc", int'(eng_start), 0);
        for (int i = 0; i < M; i++) begin
            for (int g = 0; g < gap; g++) begin
                cyc();
                if (stray && i == 2 && g == 0) begin
                    eng_datapoint_done = '0;
                    eng_datapoint_done[1-c] = 1'b1;
                    start = 1'b1;
                end else begin
                    eng_datapoint_done = '0;
                    start = 1'b0;
                end
            end
            cyc();
            start = 1'b0;
            r = {P{8'hEE}};
            r[c*W +: W] = W'(base + i);
            eng_results = r;
            eng_datapoint_done = '0;
            eng_datapoint_done[c] = 1'b1;
            w.addr = RB'(c*M + i);
            w.data = W'(base + i);
            exp_q.push_back(w);
            cyc();
            eng_datapoint_done = '0;
        end
        for (int d = 0; d < done_gap; d++) begin
            @(negedge clk);
            chk("no_early_launch", int'(eng_start), 0);
            chk("busy_drain", int'(busy), 1);
            cyc();
        end
        eng_all_done[c] = 1'b1;
    endtask

    task automatic wait_done(input int runs, input bit poke_start);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        if (!found) begin
            timeout("done_wait");
            return;
        end
        chk("busy_at_done", int'(busy), 1);
        if (poke_start) start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("done_pulse_1cyc", int'(done), 0);
        chk("no_restart", int'(eng_start), 0);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, runs);
        chk("sb_empty", exp_q.size(), 0);
        chk("idle_x_en", int'(X_read_en), 0);
    endtask

    initial begin
        vec_t vt[4];
        bit   found;

        total = 0;
        bad = 0;
        done_cnt = 0;
        reset = 1'b1;
        start = 1'b0;
        bias_terms = '0;
        eng_datapoint_done = '0;
        eng_all_done = '0;
        eng_results = '0;
        eng_X_read_en = '0;
        eng_X_read_address = '0;
        eng_Y_read_en = '0;
        eng_Y_read_address = '0;

        vt[0] = '{16'h0703, 2'b11, {9'h1FF, 9'h055}, 2'b11, {5'h1F, 5'h0A}, 8'h03, 1'b0, 9'h055, 1'b0, 5'h0A};
        vt[1] = '{16'hA53C, 2'b01, {9'h000, 9'h1AB}, 2'b10, {5'h00, 5'h15}, 8'h3C, 1'b0, 9'h1AB, 1'b0, 5'h15};
        vt[2] = '{16'h00FF, 2'b10, {9'h123, 9'h000}, 2'b01, {5'h11, 5'h00}, 8'hFF, 1'b0, 9'h000, 1'b0, 5'h00};
        vt[3] = '{16'h8001, 2'b11, {9'h0F0, 9'h10F}, 2'b11, {5'h03, 5'h1C}, 8'h01, 1'b0, 9'h10F, 1'b0, 5'h1C};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_wr_en", int'(RES_write_en), 0);
        chk("rst_wr_addr", int'(RES_write_address), 0);
        chk("rst_wr_data", int'(RES_write_data_in), 0);
        chk("rst_x_en", int'(X_read_en), 0);
        chk("rst_y_en", int'(Y_read_en), 0);
        cyc();
        reset = 1'b0;

        // Idle mux checks: col is 0 after reset and the RAM enables stay off.
        for (int i = 0; i < 4; i++) begin
            cyc();
            bias_terms = vt[i].bias;
            eng_X_read_en = vt[i].xen;
            eng_X_read_address = vt[i].xa;
            eng_Y_read_en = vt[i].yen;
            eng_Y_read_address = vt[i].ya;
            @(negedge clk);
            chk("vec_bias", int'(eng_bias_term), int'(vt[i].e_bias));
            chk("vec_x_en", int'(X_read_en), int'(vt[i].e_xen));
            chk("vec_x_addr", int'(X_read_address), int'(vt[i].e_xa));
            chk("vec_y_en", int'(Y_read_en), int'(vt[i].e_yen));
            chk("vec_y_addr", int'(Y_read_address), int'(vt[i].e_ya));
        end

        // Run 1: basic ordering, bias select, port arbitration, DRAIN gating.
        cyc();
        bias_terms = {8'd7, 8'd3};
        eng_X_read_en = 2'b11;
        eng_X_read_address = {9'h1FF, 9'h055};
        eng_Y_read_en = 2'b11;
        eng_Y_read_address = {5'h1F, 5'h0A};
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_engine(0, 10, 1, 3, 1'b0);
        run_engine(1, 20, 2, 2, 1'b0);
        wait_done(1, 1'b0);

        // Run 2: all_done still high from run 1, stray pulses and starts mid-run, start during DONE.
        cyc();
        bias_terms = {8'd9, 8'd5};
        eng_X_read_en = 2'b10;
        eng_Y_read_en = 2'b01;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_engine(0, 30, 2, 0, 1'b1);
        run_engine(1, 40, 1, 0, 1'b0);
        wait_done(2, 1'b1);

        // Run 3: reset while collecting row 2 of column 0.
        cyc();
        eng_all_done = '0;
        eng_X_read_en = 2'b11;
        eng_Y_read_en = 2'b11;
        start = 1'b1;
        cyc();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (eng_start != '0) found = 1'b1;
        end
        if (!found) timeout("rst_run_start");
        for (int i = 0; i < 2; i++) begin
            cyc();
            eng_results = {8'hEE, W'(70 + i)};
            eng_datapoint_done = 2'b01;
            exp_q.push_back('{RB'(i), W'(70 + i)});
            cyc();
            eng_datapoint_done = '0;
        end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_eng_start", int'(eng_start), 0);
        chk("midrst_wr_en", int'(RES_write_en), 0);
        chk("midrst_sb_empty", exp_q.size(), 0);
        cyc();
        eng_all_done = 2'b01;
        repeat (4) cyc();

        // Run 4: clean run after the interrupted one.
        eng_all_done = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_engine(0, 50, 1, 1, 1'b0);
        run_engine(1, 60, 1, 1, 1'b0);
        wait_done(3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
